nonce_result_scanner: RTL and testbench

NONCE_RESULT_SCANNER -- requirements
Module: nonce_result_scanner

---
 rtl/nonce_result_scanner.sv | 223 ++++++++++++++++++++++
 tb/tb_nonce_result_scanner.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_result_scanner.sv
// nonce_result_scanner
// Walks a block of NUM_NONCES consecutive 32-bit hash words in a synchronous
// memory. It tracks the smallest hash, its index, and how many hashes fall
// strictly below a difficulty target. When the scan ends it publishes the
// results on its outputs and writes a two-word report back to memory.
// Memory read latency is one cycle: data for the address driven in cycle n is
// sampled at the end of cycle n+1.

module nonce_result_scanner #(
  parameter int NUM_NONCES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] result_addr,
  input  logic [15:0] report_addr,
  input  logic [31:0] target,
  output logic        done,
  output logic        found,
  output logic [3:0]  best_nonce,
  output logic [31:0] best_hash,
  output logic [4:0]  hit_count,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  // Index of the final hash word in the block.
  localparam logic [3:0] LAST_IDX = 4'(NUM_NONCES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_FINAL,
    S_WR0,
    S_WR1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  // Operands captured when a scan is accepted.
  logic [15:0] r_result_addr;
  logic [15:0] r_report_addr;
  logic [31:0] r_target;

  // Read address sequencer and sample pipeline.
  logic [3:0]  r_rd_idx;
  logic        r_rd_done;
  logic        r_smp_vld;
  logic [3:0]  r_smp_idx;

  // Running statistics for the scan in progress.
  logic [31:0] r_run_min;
  logic [3:0]  r_run_idx;
  logic [4:0]  r_run_hits;
  logic        r_run_found;

  // Published results of the last completed scan.
  logic        r_found;
  logic [3:0]  r_best_nonce;
  logic [31:0] r_best_hash;
  logic [4:0]  r_hit_count;

  logic        w_accept;
  logic        w_sample;
  logic        w_last_smp;
  logic        w_is_hit;
  logic        w_is_min;
  logic [31:0] w_report_word0;

  // A start pulse is honoured only while idle; otherwise it is ignored.
  assign w_accept   = (r_state == S_IDLE) && start;
  // A sample is due whenever an address was issued in the previous READ cycle.
  assign w_sample   = (r_state == S_READ) && r_smp_vld;
  // Once every address is issued, the pending sample is the final one.
  assign w_last_smp = w_sample && r_rd_done;
  // Both comparisons are strict and unsigned; ties keep the earlier index.
  assign w_is_hit   = mem_read_data < r_target;
  assign w_is_min   = mem_read_data < r_run_min;

  assign w_report_word0 = {r_found, 22'd0, r_hit_count, r_best_nonce};

  assign mem_clk    = clk;
  assign found      = r_found;
  assign best_nonce = r_best_nonce;
  assign best_hash  = r_best_hash;
  assign hit_count  = r_hit_count;

  // State register; reset forces IDLE immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and memory-port / done outputs decoded from the state.
  always_comb begin
    w_state_next   = r_state;
    done           = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = 16'd0;
    mem_write_data = 32'd0;
    case (r_state)
      S_IDLE: begin
        done = 1'b1;
        if (start) begin
          w_state_next = S_READ;
        end
      end
      S_READ: begin
        // The extra cycle after the last address only collects data.
        if (!r_rd_done) begin
          mem_addr = r_result_addr + {12'd0, r_rd_idx};
        end
        if (w_last_smp) begin
          w_state_next = S_FINAL;
        end
      end
      S_FINAL: begin
        w_state_next = S_WR0;
      end
      S_WR0: begin
        mem_we         = 1'b1;
        mem_addr       = r_report_addr;
        mem_write_data = w_report_word0;
        w_state_next   = S_WR1;
      end
      S_WR1: begin
        mem_we         = 1'b1;
        mem_addr       = r_report_addr + 16'd1;
        mem_write_data = r_best_hash;
        w_state_next   = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Capture the scan operands on an accepted start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_result_addr <= 16'd0;
      r_report_addr <= 16'd0;
      r_target      <= 32'd0;
    end else if (w_accept) begin
      r_result_addr <= result_addr;
      r_report_addr <= report_addr;
      r_target      <= target;
    end
  end

  // Issue one read address per READ cycle and track which index each sample belongs to.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_idx  <= 4'd0;
      r_rd_done <= 1'b0;
      r_smp_vld <= 1'b0;
      r_smp_idx <= 4'd0;
    end else if (w_accept) begin
      r_rd_idx  <= 4'd0;
      r_rd_done <= 1'b0;
      r_smp_vld <= 1'b0;
      r_smp_idx <= 4'd0;
    end else if (r_state == S_READ) begin
      // The address on the bus this cycle returns data next cycle.
      r_smp_vld <= !r_rd_done;
      r_smp_idx <= r_rd_idx;
      if (!r_rd_done) begin
        if (r_rd_idx == LAST_IDX) begin
          r_rd_done <= 1'b1;
        end else begin
          r_rd_idx <= r_rd_idx + 4'd1;
        end
      end
    end
  end

  // Fold each returned hash into the running minimum and hit statistics.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_run_min   <= 32'hFFFF_FFFF;
      r_run_idx   <= 4'd0;
      r_run_hits  <= 5'd0;
      r_run_found <= 1'b0;
    end else if (w_accept) begin
      r_run_min   <= 32'hFFFF_FFFF;
      r_run_idx   <= 4'd0;
      r_run_hits  <= 5'd0;
      r_run_found <= 1'b0;
    end else if (w_sample) begin
      if (w_is_hit) begin
        r_run_hits  <= r_run_hits + 5'd1;
        r_run_found <= 1'b1;
      end
      if (w_is_min) begin
        r_run_min <= mem_read_data;
        r_run_idx <= r_smp_idx;
      end
    end
  end

  // Publish the scan results in FINAL; they hold until the next scan's FINAL.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_found      <= 1'b0;
      r_best_nonce <= 4'd0;
      r_best_hash  <= 32'hFFFF_FFFF;
      r_hit_count  <= 5'd0;
    end else if (r_state == S_FINAL) begin
      r_found      <= r_run_found;
      r_best_nonce <= r_run_idx;
      r_best_hash  <= r_run_min;
      r_hit_count  <= r_run_hits;
    end
  end

endmodule

// File: tb/tb_nonce_result_scanner.sv
// Directed bench for nonce_result_scanner: a table of scans with hand-computed
// results, followed by hand-written sequences for back-to-back start and for
// reset during READ and during the report write.

module tb_nonce_result_scanner;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [15:0] result_addr;
  logic [15:0] report_addr;
  logic [31:0] target;
  logic        done;
  logic        found;
  logic [3:0]  best_nonce;
  logic [31:0] best_hash;
  logic [4:0]  hit_count;
  logic        mem_clk;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  // Bench-side preload port into the memory model.
  logic        tb_we;
  logic [15:0] tb_addr;
  logic [31:0] tb_data;

  logic [31:0] mem [0:65535];
  logic [15:0] wr_log [0:255];
  int          wr_cnt = 0;
  int          wr_base;

  int n_cmp = 0;
  int n_bad = 0;

  logic        prev_found;
  logic [4:0]  prev_hits;
  logic [3:0]  prev_nonce;
  logic [31:0] prev_hash;

  typedef struct {
    logic [15:0] ra;
    logic [15:0] rp;
    logic [31:0] tgt;
    int          pat;
    logic        found;
    logic [4:0]  hits;
    logic [3:0]  nonce;
    logic [31:0] hash;
    logic [31:0] w0;
  } vec_t;

  vec_t vecs [7];

  nonce_result_scanner #(.NUM_NONCES(16)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .result_addr    (result_addr),
    .report_addr    (report_addr),
    .target         (target),
    .done           (done),
    .found          (found),
    .best_nonce     (best_nonce),
    .best_hash      (best_hash),
    .hit_count      (hit_count),
    .mem_clk        (mem_clk),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: one-cycle read latency, write port used by the DUT,
  // separate preload port used by the bench; DUT writes are logged in order.
  always @(posedge clk) begin
    mem_read_data <= mem[mem_addr];
    if (tb_we) mem[tb_addr] <= tb_data;
    if (mem_we) begin
      mem[mem_addr] <= mem_write_data;
      if (wr_cnt < 256) wr_log[wr_cnt] <= mem_addr;
      wr_cnt <= wr_cnt + 1;
    end
  end

  function automatic logic [31:0] hash_of(input int pat, input int k);
    case (pat)
      0: return (32'(k) << 24) + 32'h10;
      1: return 32'hFFFF_FFFF;
      2: return (k == 3 || k == 9) ? 32'h20 : 32'h40;
      3: return 32'h1000 - (32'(k) << 4);
      4: return (k == 6 || k == 12) ? 32'h5 : 32'h1000 + 32'(k);
      default: return (k == 15) ? 32'h0 : 32'h7FFF_FFFF + 32'(k);
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_prev_reset();
    prev_found = 1'b0;
    prev_hits  = 5'd0;
    prev_nonce = 4'd0;
    prev_hash  = 32'hFFFF_FFFF;
  endtask

  task automatic poke(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_addr = a; tb_data = d;
  endtask

  // Report sentinels first, so hash words win where the two regions overlap.
  task automatic preload(input vec_t v);
    logic [15:0] a;
    poke(v.rp, 32'hDEAD_BEEF);
    a = v.rp + 16'd1;
    poke(a, 32'hDEAD_BEEF);
    for (int k = 0; k < 16; k++) begin
      a = v.ra + 16'(k);
      poke(a, hash_of(v.pat, k));
    end
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  // Drive start for one edge (E0); afterwards scramble the operands so that
  // only the latched copies can produce correct results.
  task automatic launch(input vec_t v);
    wr_base     = wr_cnt;
    start       = 1'b1;
    result_addr = v.ra;
    report_addr = v.rp;
    target      = v.tgt;
    @(posedge clk); #1;
    start       = 1'b0;
    result_addr = ~v.ra;
    report_addr = ~v.rp;
    target      = ~v.tgt;
  endtask

  // Entered #1 after E0; leaves #1 after the edge where done rises.
  task automatic track(input vec_t v);
    int          lat;
    logic [15:0] ea;
    logic [15:0] rp1;
    lat = -1;
    for (int cyc = 0; cyc <= 40; cyc++) begin
      if (cyc < 16) begin
        ea = v.ra + 16'(cyc);
        chk("rd_addr", {16'd0, mem_addr}, {16'd0, ea});
        chk("rd_we", {31'd0, mem_we}, 32'd0);
      end
      if (cyc == 8) begin
        chk("busy_done", {31'd0, done}, 32'd0);
        chk("hold_found", {31'd0, found}, {31'd0, prev_found});
        chk("hold_hits", {27'd0, hit_count}, {27'd0, prev_hits});
        chk("hold_nonce", {28'd0, best_nonce}, {28'd0, prev_nonce});
        chk("hold_hash", best_hash, prev_hash);
        // A start during READ must be ignored.
        start = 1'b1; result_addr = 16'hAAAA; report_addr = 16'h5555; target = 32'd0;
      end
      if (cyc == 9) start = 1'b0;
      if (done) begin
        lat = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    chk("latency", lat, 32'd20);
    chk("found", {31'd0, found}, {31'd0, v.found});
    chk("hit_count", {27'd0, hit_count}, {27'd0, v.hits});
    chk("best_nonce", {28'd0, best_nonce}, {28'd0, v.nonce});
    chk("best_hash", best_hash, v.hash);
    chk("idle_we", {31'd0, mem_we}, 32'd0);
    chk("idle_addr", {16'd0, mem_addr}, 32'd0);
    chk("idle_wdata", mem_write_data, 32'd0);
    rp1 = v.rp + 16'd1;
    chk("wr_count", wr_cnt - wr_base, 32'd2);
    chk("wr0_addr", {16'd0, wr_log[wr_base]}, {16'd0, v.rp});
    chk("wr1_addr", {16'd0, wr_log[wr_base + 1]}, {16'd0, rp1});
    chk("report_w0", mem[v.rp], v.w0);
    chk("report_w1", mem[rp1], v.hash);
    prev_found = v.found;
    prev_hits  = v.hits;
    prev_nonce = v.nonce;
    prev_hash  = v.hash;
    $display("scan ra=%h rp=%h tgt=%h: found=%0d hits=%0d nonce=%0d hash=%h w0=%h lat=%0d",
             v.ra, v.rp, v.tgt, found, hit_count, best_nonce, best_hash, mem[v.rp], lat);
  endtask

  task automatic run_vec(input vec_t v);
    preload(v);
    @(negedge clk);
    launch(v);
    track(v);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_addr"}, {16'd0, mem_addr}, 32'd0);
    chk({tag, "_wdata"}, mem_write_data, 32'd0);
    chk({tag, "_found"}, {31'd0, found}, 32'd0);
    chk({tag, "_nonce"}, {28'd0, best_nonce}, 32'd0);
    chk({tag, "_hash"}, best_hash, 32'hFFFF_FFFF);
    chk({tag, "_hits"}, {27'd0, hit_count}, 32'd0);
  endtask

  initial begin
    int          snap;
    logic [15:0] a;

    // ra, rp, target, pattern, found, hits, nonce, hash, report word 0
    vecs[0] = '{16'h0100, 16'h0200, 32'h0500_0000, 0, 1'b1, 5'd5,  4'd0,  32'h0000_0010, 32'h8000_0050};
    vecs[1] = '{16'h0300, 16'h0400, 32'hFFFF_FFFF, 1, 1'b0, 5'd0,  4'd0,  32'hFFFF_FFFF, 32'h0000_0000};
    vecs[2] = '{16'h0500, 16'h0600, 32'h0000_0020, 2, 1'b0, 5'd0,  4'd3,  32'h0000_0020, 32'h0000_0003};
    // 16 hits sets bit 8 of the packed word: {found, 22'b0, hits[4:0], nonce[3:0]}.
    vecs[3] = '{16'h0700, 16'h0800, 32'hFFFF_FFFF, 2, 1'b1, 5'd16, 4'd3,  32'h0000_0020, 32'h8000_0103};
    vecs[4] = '{16'hFFF8, 16'hFFFF, 32'h0000_0F80, 3, 1'b1, 5'd7,  4'd15, 32'h0000_0F10, 32'h8000_007F};
    vecs[5] = '{16'h1000, 16'h2000, 32'h0000_1005, 4, 1'b1, 5'd7,  4'd6,  32'h0000_0005, 32'h8000_0076};
    vecs[6] = '{16'h3000, 16'h4000, 32'h8000_0000, 5, 1'b1, 5'd2,  4'd15, 32'h0000_0000, 32'h8000_002F};

    reset_n = 1'b0; start = 1'b0; result_addr = 16'd0; report_addr = 16'd0; target = 32'd0;
    tb_we = 1'b0; tb_addr = 16'd0; tb_data = 32'd0;
    set_prev_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("por");
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Back-to-back: start raised in the very cycle done rises.
    preload(vecs[6]);
    run_vec(vecs[2]);
    launch(vecs[6]);
    track(vecs[6]);

    // Reset during READ (at E10): immediate abort, no report write.
    preload(vecs[0]);
    @(negedge clk);
    launch(vecs[0]);
    repeat (10) @(posedge clk);
    #1;
    snap = wr_cnt;
    reset_n = 1'b0;
    #1;
    chk_reset_state("rst_read");
    $display("reset during READ: done=%0d we=%0d found=%0d hash=%h", done, mem_we, found, best_hash);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    chk("rst_read_nowrite", wr_cnt - snap, 32'd0);
    chk("rst_read_sentinel", mem[16'h0200], 32'hDEAD_BEEF);
    chk("rst_read_idle", {31'd0, done}, 32'd1);
    set_prev_reset();
    run_vec(vecs[0]);

    // Reset during WR0: the report must never reach memory.
    preload(vecs[6]);
    @(negedge clk);
    launch(vecs[6]);
    repeat (18) @(posedge clk);
    #1;
    chk("wr0_we", {31'd0, mem_we}, 32'd1);
    chk("wr0_addr_live", {16'd0, mem_addr}, 32'h0000_4000);
    chk("wr0_wdata_live", mem_write_data, 32'h8000_002F);
    snap = wr_cnt;
    reset_n = 1'b0;
    #1;
    chk_reset_state("rst_wr");
    $display("reset during WR0: done=%0d we=%0d addr=%h", done, mem_we, mem_addr);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_wr_nowrite", wr_cnt - snap, 32'd0);
    chk("rst_wr_sentinel0", mem[16'h4000], 32'hDEAD_BEEF);
    a = 16'h4001;
    chk("rst_wr_sentinel1", mem[a], 32'hDEAD_BEEF);
    set_prev_reset();
    run_vec(vecs[3]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
